// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Front/back end for the M-bit subtractor stage. Operands A and B are
//   captured from the switches on successive load presses. One cycle after
//   B is captured, the subtractor's result and flags are latched into
//   stable output registers for the display. A third press starts the
//   next operation by capturing a new A.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous reset, active-high
//   sw     : switch value sampled as an operand
//   load   : load button level; its rising edge is detected here
//   clear  : synchronous soft clear, active-high
//   A, B   : registered operands driven to the subtractor
//   R_in   : subtractor result
//   C_in, N_in, V_in, Z_in : subtractor flags
//   R_out  : registered result
//   flags  : registered flags {C,N,V,Z}
//   state  : current FSM encoding for the LEDs
//   done   : high while R_out/flags hold a valid result
module operand_sequencer #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] sw,
    input  logic         load,
    input  logic         clear,
    output logic [M-1:0] A,
    output logic [M-1:0] B,
    input  logic [M-1:0] R_in,
    input  logic         C_in,
    input  logic         N_in,
    input  logic         V_in,
    input  logic         Z_in,
    output logic [M-1:0] R_out,
    output logic [3:0]   flags,
    output logic [1:0]   state,
    output logic         done
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    state_t cur;
    logic   load_prev;
    logic   ld_edge;

    assign ld_edge = load & ~load_prev;
    assign state   = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset high so a button held through reset gives no edge.
            load_prev <= 1'b1;
            cur       <= S_A;
            A         <= '0;
            B         <= '0;
            R_out     <= '0;
            flags     <= 4'b0000;
            done      <= 1'b0;
        end else begin
            // Keeps sampling during clear so a press held across clear
            // is not seen as a new edge afterwards.
            load_prev <= load;
            if (clear) begin
                cur   <= S_A;
                A     <= '0;
                B     <= '0;
                R_out <= '0;
                flags <= 4'b0000;
                done  <= 1'b0;
            end else begin
                unique case (cur)
                    S_A: begin
                        if (ld_edge) begin
                            A   <= sw;
                            cur <= S_B;
                        end
                    end
                    S_B: begin
                        if (ld_edge) begin
                            B   <= sw;
                            cur <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        // The subtractor has had a full cycle to settle on
                        // the new B; presses in this cycle are dropped.
                        R_out <= R_in;
                        flags <= {C_in, N_in, V_in, Z_in};
                        done  <= 1'b1;
                        cur   <= S_SHOW;
                    end
                    S_SHOW: begin
                        // R_out/flags stay frozen until the next S_EXEC.
                        if (ld_edge) begin
                            A    <= sw;
                            done <= 1'b0;
                            cur  <= S_B;
                        end
                    end
                    default: cur <= S_A;
                endcase
            end
        end
    end

endmodule
